// File: rtl/apb_master_nslv.sv
// CPU-side APB4 master that decodes one address window per slave and drives
// NUM_SLAVES one-hot PSEL lines, with an optional ACCESS-phase timeout.
module apb_master_nslv #(
    parameter int          NUM_SLAVES = 9,
    parameter int          DATA_W     = 32,
    parameter int          SLOT_BITS  = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          TIMEOUT    = 255
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         req,
    input  logic                         write,
    input  logic [31:0]                  addr,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W/8-1:0]          wstrb,
    output logic [DATA_W-1:0]            rdata,
    output logic                         ready,
    output logic                         err,
    output logic                         busy,
    output logic [31:0]                  PADDR,
    output logic                         PWRITE,
    output logic [NUM_SLAVES-1:0]        PSEL,
    output logic                         PENABLE,
    output logic [DATA_W-1:0]            PWDATA,
    output logic [DATA_W/8-1:0]          PSTRB,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
);
    localparam int ADDR_W  = 32;
    localparam int STRB_W  = DATA_W / 8;
    localparam int IDX_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit TO_EN   = (TIMEOUT > 0);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    miss_q, miss_d;
    logic [ADDR_W-1:0]       paddr_q, paddr_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_W-1:0]       pwdata_q, pwdata_d;
    logic [STRB_W-1:0]       pstrb_q, pstrb_d;
    logic [NUM_SLAVES-1:0]   psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    busy_q, busy_d;

    logic [ADDR_W-1:0]       offset;
    logic [ADDR_W-1:0]       slot;
    logic                    hit;
    logic [IDX_W-1:0]        dec_idx;
    logic                    sel_ready;
    logic                    sel_err;
    logic [DATA_W-1:0]       sel_rdata;

    assign offset    = addr - BASE_ADDR;
    assign slot      = offset >> SLOT_BITS;
    assign hit       = (addr >= BASE_ADDR) && (slot < ADDR_W'(NUM_SLAVES));
    assign dec_idx   = slot[IDX_W-1:0];

    // Only the latched target slave is ever looked at; the others are don't-care.
    assign sel_ready = PREADY[idx_q];
    assign sel_err   = PSLVERR[idx_q];
    assign sel_rdata = PRDATA[idx_q*DATA_W +: DATA_W];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        miss_d    = miss_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        rdata_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (hit) begin
                        state_d   = S_SETUP;
                        idx_d     = dec_idx;
                        paddr_d   = addr;
                        pwrite_d  = write;
                        pwdata_d  = wdata;
                        pstrb_d   = write ? wstrb : '0;
                        psel_d    = '0;
                        psel_d[dec_idx] = 1'b1;
                        penable_d = 1'b0;
                    end else begin
                        state_d = S_RESP;
                        miss_d  = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            S_ACCESS: begin
                // A ready slave wins even on the cycle the timeout would fire.
                if (sel_ready) begin
                    state_d   = S_RESP;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    ready_d   = 1'b1;
                    err_d     = sel_err;
                    rdata_d   = pwrite_q ? '0 : sel_rdata;
                end else if (TO_EN && (cnt_q == CNT_W'(TO_LAST))) begin
                    state_d   = S_RESP;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    ready_d   = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                // A decode miss spends one silent RESP cycle before its error pulse.
                if (miss_q) begin
                    miss_d  = 1'b0;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            miss_q    <= 1'b0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            miss_q    <= miss_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
        end
    end

    assign rdata   = rdata_q;
    assign ready   = ready_q;
    assign err     = err_q;
    assign busy    = busy_q;
    assign PADDR   = paddr_q;
    assign PWRITE  = pwrite_q;
    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign PWDATA  = pwdata_q;
    assign PSTRB   = pstrb_q;

endmodule
